uart_echo_ctrl: RTL

Sequencer between a CoreUART-style byte interface (rxrdy/oen receive, txrdy/wen transmit) and itself. It reads each received byte, buffers it in a small FIFO, and writes it back to the UART transmitter, forming the echo path. It owns the UART strobes: no other block drives oen or wen. Status counters and a drop flag are exported for debug/LEDs.

---
 rtl/uart_echo_pkg.sv | 20 ++
 rtl/uart_echo_ctrl_fifo.sv | 49 ++++
 rtl/uart_echo_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and sizing for the UART echo controller.
package uart_echo_pkg;

    localparam int DEF_FIFO_DEPTH = 8;
    localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_READ,
        RX_CLR
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_STROBE,
        TX_FALL,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/uart_echo_ctrl_fifo.sv
// Synchronous byte FIFO for the echo path; the head entry is always visible on rdata.
module echo_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo sequencer: reads bytes from a CoreUART-style receiver, buffers them and writes them back.
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int TX_FALL_TIMEOUT = 4,
    parameter int CNT_W           = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          echo_en,
    input  logic                          rxrdy,
    input  logic [7:0]                    uart_rdata,
    output logic                          oen,
    input  logic                          txrdy,
    output logic                          wen,
    output logic [7:0]                    uart_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              rx_count,
    output logic [CNT_W-1:0]              tx_count,
    output logic                          drop
);
    localparam int                TMR_W    = $clog2(TX_FALL_TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TX_FALL_TIMEOUT - 1);

    rx_state_t        rx_state;
    tx_state_t        tx_state;
    logic             push_q;
    logic [7:0]       rx_byte;
    logic [7:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [TMR_W-1:0] fall_tmr;

    assign pop = (tx_state == TX_IDLE) && !fifo_empty && txrdy;

    echo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .pop   (pop),
        .wdata (rx_byte),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Receive side: one-cycle oen pulse, then hold off until rxrdy drops so a byte is never read twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            oen      <= 1'b1;
            push_q   <= 1'b0;
            rx_count <= '0;
            drop     <= 1'b0;
        end else begin
            push_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxrdy && !fifo_full) begin
                        oen      <= 1'b0;
                        rx_state <= RX_READ;
                    end
                end
                RX_READ: begin
                    oen      <= 1'b1;
                    push_q   <= echo_en;
                    drop     <= drop | ~echo_en;
                    rx_count <= rx_count + CNT_W'(1);
                    rx_state <= RX_CLR;
                end
                RX_CLR: begin
                    if (!rxrdy) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_READ) rx_byte <= uart_rdata;
    end

    // Transmit side: a UART that never lowers txrdy after a strobe is tolerated via the fall timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            wen        <= 1'b1;
            uart_wdata <= '0;
            tx_count   <= '0;
            fall_tmr   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        uart_wdata <= head;
                        wen        <= 1'b0;
                        tx_state   <= TX_STROBE;
                    end
                end
                TX_STROBE: begin
                    wen      <= 1'b1;
                    tx_count <= tx_count + CNT_W'(1);
                    fall_tmr <= '0;
                    tx_state <= TX_FALL;
                end
                TX_FALL: begin
                    if (!txrdy) begin
                        tx_state <= TX_BUSY;
                    end else if (fall_tmr == TMR_LAST) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        fall_tmr <= fall_tmr + TMR_W'(1);
                    end
                end
                TX_BUSY: begin
                    if (txrdy) tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
